// File: rtl/othello_flip_engine.sv
// Othello move engine: owns the board, validates a move at the cursor,
// scans all eight directions, flips captured disks and issues one redraw
// request per changed cell (flips first, placed disk last).
//
// Optional feature macro: OTHELLO_SCORE_EN (disk-count registers).
//
// Ports:
//   clock, resetn              clock, asynchronous active-low reset
//   init                       synchronous reload of the opening position
//   start, side, cur_x, cur_y  move request (side 0 = black, 1 = white)
//   busy, done                 move in progress / one-cycle completion pulse
//   valid_move, flip_count     result of the last move, held until next start
//   draw_valid/ready/x/y/side  redraw request handshake to the plot stage
//   rd_x, rd_y, rd_cell        combinational board read (00 empty, 01 B, 10 W)
//   black_count, white_count   disk totals (zero unless OTHELLO_SCORE_EN)
module othello_flip_engine #(
  parameter int unsigned BOARD_W = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               init,
  input  logic               start,
  input  logic               side,
  input  logic [BOARD_W-1:0] cur_x,
  input  logic [BOARD_W-1:0] cur_y,
  output logic               busy,
  output logic               done,
  output logic               valid_move,
  output logic [4:0]         flip_count,
  output logic               draw_valid,
  input  logic               draw_ready,
  output logic [BOARD_W-1:0] draw_x,
  output logic [BOARD_W-1:0] draw_y,
  output logic               draw_side,
  input  logic [BOARD_W-1:0] rd_x,
  input  logic [BOARD_W-1:0] rd_y,
  output logic [1:0]         rd_cell,
  output logic [6:0]         black_count,
  output logic [6:0]         white_count
);

  localparam int unsigned N     = 1 << BOARD_W;
  localparam int unsigned CELLS = N * N;
  localparam int unsigned IW    = 2 * BOARD_W;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] BLACK = 2'b01;
  localparam logic [1:0] WHITE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_SCAN, S_FLIP, S_PLACE, S_DONE
  } state_e;

  // Opening position: centre diagonal white, anti-diagonal black.
  function automatic logic [1:0] opening_cell(input logic [IW-1:0] idx);
    logic [BOARD_W-1:0] x, y, lo, hi;
    x  = idx[BOARD_W-1:0];
    y  = idx[IW-1:BOARD_W];
    lo = BOARD_W'(N / 2 - 1);
    hi = BOARD_W'(N / 2);
    if ((x == lo && y == lo) || (x == hi && y == hi)) return WHITE;
    if ((x == lo && y == hi) || (x == hi && y == lo)) return BLACK;
    return EMPTY;
  endfunction

  // Per-direction deltas (two's complement, wrap is masked by edge_*).
  // Order: N, NE, E, SE, S, SW, W, NW.
  function automatic logic [BOARD_W-1:0] dlt_x(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: return BOARD_W'(1);
      3'd5, 3'd6, 3'd7: return '1;
      default:          return '0;
    endcase
  endfunction

  function automatic logic [BOARD_W-1:0] dlt_y(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: return '1;
      3'd3, 3'd4, 3'd5: return BOARD_W'(1);
      default:          return '0;
    endcase
  endfunction

  // True when stepping from coordinate c in direction d leaves the board.
  function automatic logic edge_x(input logic [BOARD_W-1:0] c, input logic [2:0] d);
    return ((d == 3'd1 || d == 3'd2 || d == 3'd3) && c == '1) ||
           ((d == 3'd5 || d == 3'd6 || d == 3'd7) && c == '0);
  endfunction

  function automatic logic edge_y(input logic [BOARD_W-1:0] c, input logic [2:0] d);
    return ((d == 3'd0 || d == 3'd1 || d == 3'd7) && c == '0) ||
           ((d == 3'd3 || d == 3'd4 || d == 3'd5) && c == '1);
  endfunction

  state_e             state_q, state_d;
  logic [1:0]         board_q [CELLS];
  logic [1:0]         board_d [CELLS];
  logic               side_q, side_d;
  logic [BOARD_W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [2:0]         dir_q, dir_d;
  logic [BOARD_W-1:0] run_q, run_d;
  logic [BOARD_W-1:0] sx_q, sx_d, sy_q, sy_d;   // last cell visited by the scan
  logic [BOARD_W-1:0] wx_q, wx_d, wy_q, wy_d;   // last cell committed by the flip walk
  logic [4:0]         flip_count_q, flip_count_d;
  logic               valid_move_q, valid_move_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               draw_valid_q, draw_valid_d;
  logic [BOARD_W-1:0] draw_x_q, draw_x_d, draw_y_q, draw_y_d;
  logic               draw_side_q, draw_side_d;

  logic [1:0]         own_c;
  logic [BOARD_W-1:0] scan_x, scan_y, flip_x, flip_y;
  logic               scan_off;
  logic [1:0]         scan_cell;
  logic               adv_dir;

  assign own_c     = side_q ? WHITE : BLACK;
  assign scan_x    = sx_q + dlt_x(dir_q);
  assign scan_y    = sy_q + dlt_y(dir_q);
  assign scan_off  = edge_x(sx_q, dir_q) || edge_y(sy_q, dir_q);
  assign scan_cell = board_q[{scan_y, scan_x}];
  assign flip_x    = wx_q + dlt_x(dir_q);
  assign flip_y    = wy_q + dlt_y(dir_q);

  // Next-state, board update and registered output values.
  always_comb begin
    state_d      = state_q;
    board_d      = board_q;
    side_d       = side_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    dir_d        = dir_q;
    run_d        = run_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    wx_d         = wx_q;
    wy_d         = wy_q;
    flip_count_d = flip_count_q;
    valid_move_d = valid_move_q;
    adv_dir      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          side_d       = side;
          tx_d         = cur_x;
          ty_d         = cur_y;
          flip_count_d = '0;
          valid_move_d = 1'b0;
          state_d      = S_CHECK;
        end
      end
      S_CHECK: begin
        if (board_q[{ty_q, tx_q}] != EMPTY) begin
          state_d = S_DONE;
        end else begin
          dir_d   = '0;
          run_d   = '0;
          sx_d    = tx_q;
          sy_d    = ty_q;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_off || scan_cell == EMPTY || (scan_cell == own_c && run_q == '0)) begin
          adv_dir = 1'b1;
        end else if (scan_cell == own_c) begin
          wx_d    = tx_q;
          wy_d    = ty_q;
          state_d = S_FLIP;
        end else begin
          run_d = run_q + BOARD_W'(1);
          sx_d  = scan_x;
          sy_d  = scan_y;
        end
      end
      S_FLIP: begin
        if (draw_ready) begin
          board_d[{flip_y, flip_x}] = own_c;
          wx_d         = flip_x;
          wy_d         = flip_y;
          run_d        = run_q - BOARD_W'(1);
          flip_count_d = flip_count_q + 5'd1;
          if (run_q == BOARD_W'(1)) adv_dir = 1'b1;
        end
      end
      S_PLACE: begin
        if (draw_ready) begin
          board_d[{ty_q, tx_q}] = own_c;
          valid_move_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared direction advance after a failed scan or a finished flip run.
    if (adv_dir) begin
      run_d = '0;
      sx_d  = tx_q;
      sy_d  = ty_q;
      if (dir_q == 3'd7) begin
        state_d = (flip_count_d != '0) ? S_PLACE : S_DONE;
      end else begin
        dir_d   = dir_q + 3'd1;
        state_d = S_SCAN;
      end
    end

    if (init) begin
      state_d      = S_IDLE;
      flip_count_d = '0;
      valid_move_d = 1'b0;
      for (int unsigned i = 0; i < CELLS; i++) board_d[i] = opening_cell(IW'(i));
    end

    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    draw_valid_d = (state_d == S_FLIP) || (state_d == S_PLACE);
    draw_x_d     = (state_d == S_FLIP) ? wx_d + dlt_x(dir_d) : tx_d;
    draw_y_d     = (state_d == S_FLIP) ? wy_d + dlt_y(dir_d) : ty_d;
    draw_side_d  = side_d;
  end

  // State and board registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < CELLS; i++) board_q[i] <= opening_cell(IW'(i));
      state_q      <= S_IDLE;
      side_q       <= 1'b0;
      tx_q         <= '0;
      ty_q         <= '0;
      dir_q        <= '0;
      run_q        <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      wx_q         <= '0;
      wy_q         <= '0;
      flip_count_q <= '0;
      valid_move_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      draw_valid_q <= 1'b0;
      draw_x_q     <= '0;
      draw_y_q     <= '0;
      draw_side_q  <= 1'b0;
    end else begin
      board_q      <= board_d;
      state_q      <= state_d;
      side_q       <= side_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      dir_q        <= dir_d;
      run_q        <= run_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      wx_q         <= wx_d;
      wy_q         <= wy_d;
      flip_count_q <= flip_count_d;
      valid_move_q <= valid_move_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      draw_valid_q <= draw_valid_d;
      draw_x_q     <= draw_x_d;
      draw_y_q     <= draw_y_d;
      draw_side_q  <= draw_side_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign valid_move = valid_move_q;
  assign flip_count = flip_count_q;
  assign draw_valid = draw_valid_q;
  assign draw_x     = draw_x_q;
  assign draw_y     = draw_y_q;
  assign draw_side  = draw_side_q;
  assign rd_cell    = board_q[{rd_y, rd_x}];

`ifdef OTHELLO_SCORE_EN
  logic [6:0] black_q, black_d, white_q, white_d;
  logic       flip_evt, place_evt;

  assign flip_evt  = (state_q == S_FLIP)  && draw_ready;
  assign place_evt = (state_q == S_PLACE) && draw_ready;

  // A flip moves one disk between totals; a placement adds one to the mover.
  always_comb begin
    black_d = black_q;
    white_d = white_q;
    if (flip_evt) begin
      if (side_q) begin
        white_d = white_q + 7'd1;
        black_d = black_q - 7'd1;
      end else begin
        black_d = black_q + 7'd1;
        white_d = white_q - 7'd1;
      end
    end
    if (place_evt) begin
      if (side_q) white_d = white_q + 7'd1;
      else        black_d = black_q + 7'd1;
    end
    if (init) begin
      black_d = 7'd2;
      white_d = 7'd2;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      black_q <= 7'd2;
      white_q <= 7'd2;
    end else begin
      black_q <= black_d;
      white_q <= white_d;
    end
  end

  assign black_count = black_q;
  assign white_count = white_q;
`else
  assign black_count = '0;
  assign white_count = '0;
`endif

endmodule

// File: tb/tb_othello_flip_engine.sv
// Bench for othello_flip_engine: a reference Othello model predicts each
// move's redraw requests (queued as a scoreboard), result and final board.
module tb_othello_flip_engine;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       init = 1'b0;
  logic       start = 1'b0;
  logic       side = 1'b0;
  logic [2:0] cur_x = '0, cur_y = '0;
  logic       busy, done, valid_move;
  logic [4:0] flip_count;
  logic       draw_valid;
  logic       draw_ready = 1'b0;
  logic [2:0] draw_x, draw_y;
  logic       draw_side;
  logic [2:0] rd_x = '0, rd_y = '0;
  logic [1:0] rd_cell;
  logic [6:0] black_count, white_count;

  othello_flip_engine #(.BOARD_W(3)) dut (
    .clock(clock), .resetn(resetn), .init(init), .start(start), .side(side),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .done(done),
    .valid_move(valid_move), .flip_count(flip_count),
    .draw_valid(draw_valid), .draw_ready(draw_ready),
    .draw_x(draw_x), .draw_y(draw_y), .draw_side(draw_side),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
    .black_count(black_count), .white_count(white_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       s;
  } req_t;

  req_t       exp_q[$];
  logic [1:0] mb [64];          // model board, index y*8+x
  logic       exp_valid;
  int         exp_fc;
  int         n_checks = 0;
  int         n_pass = 0;
  int         dv_cycles = 0;
  int         ready_mode = 1;   // 0 hold low, 1 hold high, 2 random

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int ddx(input int d);
    case (d)
      1, 2, 3: return 1;
      5, 6, 7: return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int ddy(input int d);
    case (d)
      0, 1, 7: return -1;
      3, 4, 5: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic bit on_board(input int x, input int y);
    return x >= 0 && x < 8 && y >= 0 && y < 8;
  endfunction

  function automatic int model_run(input int x, input int y, input int d, input logic [1:0] own);
    logic [1:0] opp;
    int cx, cy, run;
    opp = own ^ 2'b11;
    cx = x + ddx(d);
    cy = y + ddy(d);
    run = 0;
    while (on_board(cx, cy) && mb[cy*8+cx] == opp) begin
      run++;
      cx += ddx(d);
      cy += ddy(d);
    end
    if (on_board(cx, cy) && mb[cy*8+cx] == own && run > 0) return run;
    return 0;
  endfunction

  function automatic int model_total(input int x, input int y, input logic s);
    int t;
    t = 0;
    if (mb[y*8+x] != 2'b00) return 0;
    for (int d = 0; d < 8; d++) t += model_run(x, y, d, s ? 2'b10 : 2'b01);
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mb[i] = 2'b00;
    mb[3*8+3] = 2'b10;
    mb[4*8+4] = 2'b10;
    mb[4*8+3] = 2'b01;
    mb[3*8+4] = 2'b01;
  endtask

  task automatic model_move(input int x, input int y, input logic s);
    logic [1:0] own;
    int r;
    own = s ? 2'b10 : 2'b01;
    exp_valid = 1'b0;
    exp_fc = 0;
    if (mb[y*8+x] != 2'b00) return;
    for (int d = 0; d < 8; d++) begin
      r = model_run(x, y, d, own);
      for (int k = 1; k <= r; k++) begin
        exp_q.push_back('{x: 3'(x + k*ddx(d)), y: 3'(y + k*ddy(d)), s: s});
        mb[(y + k*ddy(d))*8 + (x + k*ddx(d))] = own;
        exp_fc++;
      end
    end
    if (exp_fc > 0) begin
      exp_q.push_back('{x: 3'(x), y: 3'(y), s: s});
      mb[y*8+x] = own;
      exp_valid = 1'b1;
    end
  endtask

  function automatic logic [127:0] model_pack();
    logic [127:0] b;
    for (int i = 0; i < 64; i++) b[i*2 +: 2] = mb[i];
    return b;
  endfunction

  function automatic int model_count(input logic [1:0] code);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) if (mb[i] == code) c++;
    return c;
  endfunction

  // ---------------- DUT helpers ----------------
  task automatic read_board(output logic [127:0] b);
    for (int i = 0; i < 64; i++) begin
      rd_x = 3'(i % 8);
      rd_y = 3'(i / 8);
      #1;
      b[i*2 +: 2] = rd_cell;
    end
  endtask

  task automatic check_board(input string tag);
    logic [127:0] b;
    read_board(b);
    check(tag, b, model_pack());
  endtask

  task automatic check_scores(input string tag);
`ifdef OTHELLO_SCORE_EN
    check({tag, "_black"}, black_count, 7'(model_count(2'b01)));
    check({tag, "_white"}, white_count, 7'(model_count(2'b10)));
`else
    check({tag, "_black"}, black_count, 7'd0);
    check({tag, "_white"}, white_count, 7'd0);
`endif
  endtask

  task automatic reset_dut();
    start = 1'b0;
    init = 1'b0;
    resetn = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  task automatic pulse_start(input logic [2:0] x, input logic [2:0] y, input logic s);
    dv_cycles = 0;
    @(posedge clock); #1;
    start = 1'b1;
    side = s;
    cur_x = x;
    cur_y = y;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic start_move(input logic [2:0] x, input logic [2:0] y, input logic s);
    model_move(int'(x), int'(y), s);
    pulse_start(x, y, s);
  endtask

  task automatic wait_done(output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (done) got = 1'b1;
    end
    if (!got) check("done_timeout", done, 1'b1);
  endtask

  task automatic wait_dv();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clock);
      if (draw_valid) got = 1'b1;
    end
    if (!got) check("draw_valid_timeout", draw_valid, 1'b1);
  endtask

  task automatic finish_move(input string tag, output int cyc);
    wait_done(cyc);
    check({tag, "_valid"}, valid_move, exp_valid);
    check({tag, "_flips"}, flip_count, 5'(exp_fc));
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check_board({tag, "_board"});
    check_scores(tag);
  endtask

  // Scoreboard: each accepted redraw request must match the next expected one.
  always @(negedge clock) begin
    req_t r;
    if (resetn && draw_valid) dv_cycles++;
    if (resetn && draw_valid && draw_ready) begin
      if (exp_q.size() == 0) begin
        check("draw_extra", exp_q.size(), 1);
      end else begin
        r = exp_q.pop_front();
        check("draw_req", {draw_x, draw_y, draw_side}, r);
      end
    end
  end

  // draw_ready driver.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       draw_ready = 1'b0;
      1:       draw_ready = 1'b1;
      default: draw_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cand[$];
    int pick;
    logic s;

    // Reset state.
    reset_dut();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_draw_valid", draw_valid, 1'b0);
    check("rst_valid_move", valid_move, 1'b0);
    check("rst_flip_count", flip_count, 5'd0);
    check_board("rst_board");
    check_scores("rst");

    // Black at (3,2): flips (3,3) then places (3,2).
    ready_mode = 1;
    start_move(3'd3, 3'd2, 1'b0);
    finish_move("mv32", cyc);
    check("mv32_flips_const", flip_count, 5'd1);

    // Occupied target: done in the 2nd cycle, no requests, no change.
    start_move(3'd3, 3'd3, 1'b0);
    finish_move("occ", cyc);
    check("occ_latency", cyc, 2);
    check("occ_no_draw", dv_cycles, 0);

    // Corner with nothing to capture: full scan, edge stops.
    start_move(3'd0, 3'd0, 1'b0);
    finish_move("corner", cyc);
    check("corner_no_draw", dv_cycles, 0);

    // Back-pressure: request held stable, board untouched, start ignored.
    reset_dut();
    ready_mode = 0;
    start_move(3'd3, 3'd2, 1'b0);
    wait_dv();
    rd_x = 3'd3;
    rd_y = 3'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("hold_valid", draw_valid, 1'b1);
      check("hold_xy", {draw_x, draw_y}, 6'o33);
      check("hold_cell", rd_cell, 2'b10);
      if (k == 1) begin
        start = 1'b1; side = 1'b1; cur_x = 3'd0; cur_y = 3'd0;
      end else begin
        start = 1'b0;
      end
    end
    ready_mode = 1;
    finish_move("hold", cyc);

    // Async reset while waiting in FLIP.
    reset_dut();
    ready_mode = 0;
    pulse_start(3'd3, 3'd2, 1'b0);
    wait_dv();
    #1 resetn = 1'b0;
    #1;
    check("arst_draw_valid", draw_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    model_reset();
    check_board("arst_board");
    @(posedge clock); #1;
    resetn = 1'b1;

    // init pulse mid-move.
    pulse_start(3'd3, 3'd2, 1'b0);
    wait_dv();
    @(posedge clock); #1;
    init = 1'b1;
    @(posedge clock); #1;
    init = 1'b0;
    check("init_draw_valid", draw_valid, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_flip_count", flip_count, 5'd0);
    check_board("init_board");
    check_scores("init");

    // Short random game with random back-pressure.
    reset_dut();
    ready_mode = 2;
    s = 1'b0;
    for (int m = 0; m < 12; m++) begin
      cand.delete();
      for (int i = 0; i < 64; i++) if (model_total(i % 8, i / 8, s) > 0) cand.push_back(i);
      if (cand.size() == 0) begin
        s = ~s;
        continue;
      end
      pick = cand[$urandom_range(0, 32'(cand.size() - 1))];
      start_move(3'(pick % 8), 3'(pick / 8), s);
      finish_move("game", cyc);
      s = ~s;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
